// File: rtl/s2p_pkg.sv
// s2p_pkg: shared FSM encoding and constants for the serial-to-parallel receiver
package s2p_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  localparam int WORD_DEF = 8;
  localparam int CNT_W = $clog2(WORD_DEF + 1);
  localparam logic PAR_EVEN = 1'b0;
endpackage

// File: rtl/s2p_out_buf.sv
// s2p_out_buf: one-entry valid/ready holding register with overrun detection
module s2p_out_buf #(
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WORD-1:0] word,
  input  logic            rdy_i,
  output logic [WORD-1:0] data_o,
  output logic            valid_o,
  output logic            overrun_o
);
  import s2p_pkg::*;
  logic take;
  always_comb take = load && (!valid_o || rdy_i);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_o <= '0;
      valid_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= load && valid_o && !rdy_i;
      if (take) begin
        data_o <= word;
        valid_o <= 1'b1;
      end else if (valid_o && rdy_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/s_to_p_rx.sv
// s_to_p_rx: MSB-first serial word receiver; S2P_PARITY_EN adds a trailing even-parity bit
module s_to_p_rx
  import s2p_pkg::*;
#(
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_n,
  input  logic            data_i,
  input  logic            rdy_i,
  output logic [WORD-1:0] data_o,
  output logic            valid_o,
  output logic            frame_err_o,
  output logic            overrun_o,
  output logic            parity_err_o
);
  localparam int CW = $clog2(WORD + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD-1:0] shift_reg, shift_n, word, ld_word;
  logic load, ferr_n, perr_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    word = {shift_reg[WORD-2:0], data_i};
    shift_n = shift_reg;
    ld_word = (state == PAR) ? shift_reg : word;
    load = 1'b0;
    ferr_n = 1'b0;
    perr_n = 1'b0;
    case (state)
      IDLE: if (!start_n) begin
        shift_n = word;
        cnt_n = CW'(1);
        state_n = SHIFT;
      end
      SHIFT: if (start_n) begin
        ferr_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end else begin
        shift_n = word;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WORD - 1)) begin
`ifdef S2P_PARITY_EN
          state_n = PAR;
`else
          state_n = IDLE;
          load = 1'b1;
`endif
        end
      end
`ifdef S2P_PARITY_EN
      PAR: begin
        state_n = IDLE;
        cnt_n = '0;
        ferr_n = start_n;
        perr_n = !start_n && ((^{shift_reg, data_i}) != PAR_EVEN);
        load = !start_n && ((^{shift_reg, data_i}) == PAR_EVEN);
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      shift_reg <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift_reg <= shift_n;
      frame_err_o <= ferr_n;
    end
  end
`ifdef S2P_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_o <= 1'b0;
    else parity_err_o <= perr_n;
  end
`else
  assign parity_err_o = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_n;
`endif
  s2p_out_buf #(.WORD(WORD)) u_buf (
    .clk(clk),
    .reset(reset),
    .load(load),
    .word(ld_word),
    .rdy_i(rdy_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .overrun_o(overrun_o)
  );
endmodule

// File: tb/tb_s_to_p_rx.sv
// tb_s_to_p_rx: scoreboard bench for the serial-to-parallel receiver
module tb_s_to_p_rx;
  logic clk = 1'b0;
  logic reset, start_n, data_i, rdy_i;
  logic [7:0] data_o;
  logic valid_o, frame_err_o, overrun_o, parity_err_o;
  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] sb[$];
  s_to_p_rx #(.WORD(8)) dut (
    .clk(clk),
    .reset(reset),
    .start_n(start_n),
    .data_i(data_i),
    .rdy_i(rdy_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .parity_err_o(parity_err_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_err_o === 1'b1) ferr_cnt++;
    if (reset === 1'b1 && overrun_o === 1'b1) ovr_cnt++;
    if (reset === 1'b1 && valid_o === 1'b1 && rdy_i === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected data_o=%h with empty scoreboard", data_o);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (data_o !== exp) begin
          errors++;
          $display("FAIL sb_word got=%h exp=%h", data_o, exp);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      start_n = 1'b0;
      data_i = w[7-i];
      tick();
    end
  endtask
  task automatic send_frame(input logic [7:0] w, input logic par_ok);
    send_bits(w, 8);
`ifdef S2P_PARITY_EN
    start_n = 1'b0;
    data_i = (^w) ^ !par_ok;
    tick();
`else
    if (par_ok !== 1'b1) $display("note: parity not built in");
`endif
  endtask
  task automatic idle(input int n);
    start_n = 1'b1;
    data_i = 1'b0;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    checks += 5;
    if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", data_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
    if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", frame_err_o); end
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_ovr got=%b exp=0", overrun_o); end
    if (parity_err_o !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b exp=0", parity_err_o); end
  endtask
  task automatic test_basic();
    rdy_i = 1'b1;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    checks += 3;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", valid_o); end
    if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", data_o); end
    idle(1);
    if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b exp=0", valid_o); end
  endtask
  task automatic test_back_to_back();
    int f0;
    f0 = ferr_cnt;
    rdy_i = 1'b1;
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    send_frame(8'h3C, 1'b1);
    checks += 6;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/3c", valid_o, data_o); end
    send_frame(8'hC3, 1'b1);
    if (valid_o !== 1'b1 || data_o !== 8'hC3) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/c3", valid_o, data_o); end
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_ovr got=%b exp=0", overrun_o); end
    idle(1);
    if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%b exp=0", valid_o); end
    if (ferr_cnt != f0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=%0d", ferr_cnt, f0); end
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
  endtask
  task automatic test_abort();
    rdy_i = 1'b1;
    send_bits(8'hFF, 5);
    idle(1);
    checks += 5;
    if (frame_err_o !== 1'b1) begin errors++; $display("FAIL abort_ferr got=%b exp=1", frame_err_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", valid_o); end
    idle(1);
    if (frame_err_o !== 1'b0) begin errors++; $display("FAIL abort_pulse got=%b exp=0", frame_err_o); end
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    if (valid_o !== 1'b1 || data_o !== 8'h81) begin errors++; $display("FAIL abort_next got=%b/%h exp=1/81", valid_o, data_o); end
    idle(1);
    if (frame_err_o !== 1'b0) begin errors++; $display("FAIL abort_clean got=%b exp=0", frame_err_o); end
  endtask
  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rdy_i = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(1);
    send_frame(8'h22, 1'b1);
    checks += 5;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%b exp=1", overrun_o); end
    if (data_o !== 8'h11 || valid_o !== 1'b1) begin errors++; $display("FAIL ovr_hold got=%b/%h exp=1/11", valid_o, data_o); end
    idle(1);
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_once got=%b exp=0", overrun_o); end
    rdy_i = 1'b1;
    tick();
    if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", valid_o); end
    if (ovr_cnt != o0 + 1) begin errors++; $display("FAIL ovr_count got=%0d exp=%0d", ovr_cnt, o0 + 1); end
  endtask
  task automatic test_reset_mid();
    rdy_i = 1'b0;
    send_frame(8'h77, 1'b1);
    send_bits(8'hFF, 3);
    checks += 4;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%b exp=1", valid_o); end
    #2 reset = 1'b0;
    #1;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL rmid_async got=%b/%h exp=0/00", valid_o, data_o); end
    start_n = 1'b1;
    tick();
    reset = 1'b1;
    rdy_i = 1'b1;
    tick();
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    if (valid_o !== 1'b1 || data_o !== 8'h5A) begin errors++; $display("FAIL rmid_next got=%b/%h exp=1/5a", valid_o, data_o); end
    idle(1);
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_drop got=%b exp=0", valid_o); end
  endtask
`ifdef S2P_PARITY_EN
  task automatic test_parity();
    rdy_i = 1'b1;
    send_frame(8'h07, 1'b0);
    checks += 4;
    if (parity_err_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL par_bad got=%b/%b exp=1/0", parity_err_o, valid_o); end
    idle(1);
    if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_pulse got=%b exp=0", parity_err_o); end
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    if (valid_o !== 1'b1 || data_o !== 8'h07) begin errors++; $display("FAIL par_good got=%b/%h exp=1/07", valid_o, data_o); end
    if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_clean got=%b exp=0", parity_err_o); end
    idle(1);
  endtask
`endif
  initial begin
    reset = 1'b0;
    start_n = 1'b1;
    data_i = 1'b0;
    rdy_i = 1'b0;
    repeat (2) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_basic();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid();
`ifdef S2P_PARITY_EN
    test_parity();
`endif
    idle(2);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/s_to_p_rx.md
Name: s_to_p_rx

Overview:
Serial-to-parallel receiver; the receive end of the team's MSB-first serial word link.
- Samples one bit per clk from a serial line while the active-low frame strobe is asserted, and assembles WORD-bit words.
- Presents each word through a one-entry output buffer with a valid/ready handshake.
- Sits between the serial link and the MPU's parallel datapath; reports framing aborts and buffer overruns.

Parameters:
WORD, 8, bits per word; legal range 2..16; counter width is $clog2(WORD+1).

Ports:
clk  input  1  clock; all sampling on the rising edge.
reset  input  1  asynchronous, active-low reset.
start_n  input  1  frame strobe, active-low; the bit on data_i is valid in every cycle where start_n=0.
data_i  input  1  serial data, MSB first.
rdy_i  input  1  consumer ready; the word transfers on a cycle where valid_o=1 and rdy_i=1.
data_o  output  WORD  assembled word; held stable while valid_o=1.
valid_o  output  1  output buffer holds an unconsumed word.
frame_err_o  output  1  one-cycle pulse: frame aborted before WORD bits.
overrun_o  output  1  one-cycle pulse: completed word dropped because the buffer was full.
parity_err_o  output  1  one-cycle pulse on parity mismatch; tied 0 when the feature is disabled.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, bit counter=0, shift register=0, data_o=0, valid_o=0, all error pulses=0.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the feature).
- IDLE:
  - start_n=0: shift in data_i as the MSB, cnt=1, go to SHIFT.
  - start_n=1: stay in IDLE; no state change.
- SHIFT:
  - start_n=0: shift_reg <= {shift_reg[WORD-2:0], data_i}, cnt+1.
  - The bit that brings cnt to WORD completes the word:
    - Without the feature: go to IDLE and perform the load step.
    - With the feature: go to PAR.
  - start_n=1 with 0<cnt<WORD: abort. Discard the partial word, pulse frame_err_o for 1 cycle, go to IDLE, cnt=0. The buffer is untouched.
- Load step:
  - Buffer empty, or rdy_i=1 in the same cycle: data_o <= word, valid_o=1 on the next cycle.
  - valid_o=1 and rdy_i=0: keep the old word, drop the new one, pulse overrun_o.
- Latency: data_o/valid_o update on the clock edge after the last data bit (after the parity bit when the feature is enabled).
- Handshake:
  - valid_o deasserts on the edge after a cycle with valid_o&rdy_i, unless a load happens in that same cycle; in that case valid_o stays 1 with the new word.
  - rdy_i is ignored while valid_o=0.
- Back-to-back frames: start_n held low continuously streams words with no gap cycle. The IDLE state samples the next MSB in the cycle immediately after completion.
- data_i is don't-care while start_n=1.
- Error pulses are mutually exclusive per cycle. A parity error takes priority over overrun; a parity-failed word is never loaded.

Optional Feature:
Macro S2P_PARITY_EN.
- Defined:
  - After WORD data bits, one extra bit is sampled in PAR (requires start_n=0) as an even-parity bit over the word.
  - Mismatch: pulse parity_err_o, discard the word.
  - Match: perform the load step.
  - start_n=1 in PAR: frame abort, frame_err_o pulse.
  - PAR always returns to IDLE.
- Undefined: no PAR state, parity_err_o tied 0, a frame is exactly WORD bits.

Decomposition:
- Shared package s2p_pkg:
  - FSM state enum {IDLE, SHIFT, PAR}.
  - Localparam CNT_W = $clog2(WORD+1).
  - Localparam for the even-parity polarity.
- Natural sub-module: s2p_out_buf, the one-entry valid/ready holding register with overrun detection. The top module keeps the FSM, counter and shift register.

Test Plan:
- WORD=8, start_n low for 8 cycles, bits 1,0,1,0,0,1,0,1, rdy_i=1 → data_o=8'hA5, valid_o=1 one cycle after bit 8, then 0.
- Two back-to-back frames 8'h3C then 8'hC3 over 16 low cycles, rdy_i=1 → two loads, no gap, no errors.
- start_n rises after 5 bits → frame_err_o=1 for 1 cycle, valid_o stays 0; next full frame 8'h81 received correctly.
- rdy_i=0, frames 8'h11 then 8'h22 → data_o=8'h11 held, overrun_o pulse at the second completion; raise rdy_i → valid_o drops.
- reset driven low after 3 bits of a frame → all outputs 0 immediately; next full frame 8'h5A received with a correct bit count.
- With S2P_PARITY_EN, frame 8'h07 + parity bit 0 → parity_err_o pulse, no load; same frame + parity bit 1 → data_o=8'h07, valid_o=1.
